// File: rtl/mac_pkg.sv
// Shared constants and saturating-add helpers for the delayed-autocorrelation MAC.
// sat_add/add_ovf are only referenced when SATURATE_EN is defined.
package mac_pkg;

   localparam int DATA_W  = 16;
   localparam int ACC_W   = 32;
   localparam int CNT_W   = 6;
   localparam int WIN_LEN = 2**CNT_W;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // Two's-complement overflow: operands agree in sign, result does not.
   function automatic logic add_ovf(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W-1:0] s;
      s = a + b;
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
   endfunction

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W-1:0] s;
      s = a + b;
      if (add_ovf(a, b))
         return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
      return s;
   endfunction

endpackage

// File: rtl/mac_cmul.sv
// Combinational conjugate complex multiply: p = a * conj(b), result kept mod 2**ACC_W.
module mac_cmul
   import mac_pkg::*;
(
   input  logic [DATA_W-1:0] a_re,
   input  logic [DATA_W-1:0] a_im,
   input  logic [DATA_W-1:0] b_re,
   input  logic [DATA_W-1:0] b_im,
   output logic [ACC_W-1:0]  p_re,
   output logic [ACC_W-1:0]  p_im
);

   logic signed [ACC_W-1:0] ar, ai, br, bi;
   logic signed [ACC_W-1:0] rr, ii, ir, ri;

   // Sign-extend to the accumulator width so the add/sub wraps exactly mod 2**ACC_W.
   assign ar = ACC_W'($signed(a_re));
   assign ai = ACC_W'($signed(a_im));
   assign br = ACC_W'($signed(b_re));
   assign bi = ACC_W'($signed(b_im));

   assign rr = ar * br;
   assign ii = ai * bi;
   assign ir = ai * br;
   assign ri = ar * bi;

   assign p_re = rr + ii;
   assign p_im = ir - ri;

endmodule

// File: rtl/mac.sv
// Delayed-autocorrelation MAC: registers x[n]*conj(x[n+4]) and sums it over 64-sample windows.
// Define SATURATE_EN for sticky saturating accumulation; default build wraps modulo 2**ACC_W.
module mac
   import mac_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] xn_re,
   input  logic [DATA_W-1:0] xn_im,
   input  logic [DATA_W-1:0] xn4_re,
   input  logic [DATA_W-1:0] xn4_im,
   output logic [ACC_W-1:0]  yn_re,
   output logic [ACC_W-1:0]  yn_im,
   output logic [CNT_W-1:0]  counter,
   output logic [ACC_W-1:0]  summer_a,
   output logic [ACC_W-1:0]  summer_b,
   output logic [ACC_W-1:0]  re,
   output logic [ACC_W-1:0]  im
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN-1);

   logic [ACC_W-1:0] p_re, p_im;
   logic [ACC_W-1:0] sum_a, sum_b;
   logic             p_vld;
   logic             win_end;

   mac_cmul u_cmul (
      .a_re (xn_re),
      .a_im (xn_im),
      .b_re (xn4_re),
      .b_im (xn4_im),
      .p_re (p_re),
      .p_im (p_im)
   );

   // Stage 1: product register, p_vld marks a fresh product for stage 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         re    <= '0;
         im    <= '0;
         p_vld <= 1'b0;
      end else begin
         p_vld <= en;
         if (en) begin
            re <= p_re;
            im <= p_im;
         end
      end
   end

   assign win_end = p_vld && (counter == LAST);

`ifdef SATURATE_EN
   // Once a channel saturates it is frozen until the window clears.
   logic sat_a, sat_b;
   logic ovf_a, ovf_b;

   always_comb begin
      sum_a = sat_a ? summer_a : sat_add(summer_a, re);
      sum_b = sat_b ? summer_b : sat_add(summer_b, im);
      ovf_a = !sat_a && add_ovf(summer_a, re);
      ovf_b = !sat_b && add_ovf(summer_b, im);
   end

   always_ff @(posedge clk) begin
      if (rst || win_end) begin
         sat_a <= 1'b0;
         sat_b <= 1'b0;
      end else if (p_vld) begin
         sat_a <= sat_a | ovf_a;
         sat_b <= sat_b | ovf_b;
      end
   end
`else
   always_comb begin
      sum_a = summer_a + re;
      sum_b = summer_b + im;
   end
`endif

   // Stage 2: accumulate; en gaps simply leave p_vld low so the window pauses.
   always_ff @(posedge clk) begin
      if (rst) begin
         summer_a <= '0;
         summer_b <= '0;
         counter  <= '0;
         yn_re    <= '0;
         yn_im    <= '0;
      end else if (p_vld) begin
         if (win_end) begin
            yn_re    <= sum_a;
            yn_im    <= sum_b;
            summer_a <= '0;
            summer_b <= '0;
            counter  <= '0;
         end else begin
            summer_a <= sum_a;
            summer_b <= sum_b;
            counter  <= counter + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mac.sv
// Self-checking bench for mac: vector table for the product stage plus a yn scoreboard.
// Honours SATURATE_EN in its reference model when the build defines it.
module tb_mac;
   import mac_pkg::*;

   logic              clk = 1'b0;
   logic              rst, en;
   logic [DATA_W-1:0] xn_re, xn_im, xn4_re, xn4_im;
   logic [ACC_W-1:0]  yn_re, yn_im, summer_a, summer_b, re, im;
   logic [CNT_W-1:0]  counter;

   mac dut (
      .clk(clk), .rst(rst), .en(en),
      .xn_re(xn_re), .xn_im(xn_im), .xn4_re(xn4_re), .xn4_im(xn4_im),
      .yn_re(yn_re), .yn_im(yn_im), .counter(counter),
      .summer_a(summer_a), .summer_b(summer_b), .re(re), .im(im)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [ACC_W-1:0] y_re;
      logic [ACC_W-1:0] y_im;
      int               due;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [DATA_W-1:0] a_re, a_im, b_re, b_im;
      logic [ACC_W-1:0]  e_re, e_im;
   } vec_t;
   vec_t vt[6];

   // Reference window state
   logic [ACC_W-1:0] m_sa, m_sb;
   logic             m_fa, m_fb;
   int               m_cnt;

   task automatic chk(input string nm, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic ref_prod(input logic [DATA_W-1:0] a, b, c, d,
                           output logic [ACC_W-1:0] pr, pi);
      longint r, i;
      r  = longint'($signed(a)) * longint'($signed(c)) + longint'($signed(b)) * longint'($signed(d));
      i  = longint'($signed(b)) * longint'($signed(c)) - longint'($signed(a)) * longint'($signed(d));
      pr = r[ACC_W-1:0];
      pi = i[ACC_W-1:0];
   endtask

   task automatic ref_acc(inout logic [ACC_W-1:0] s, inout logic f, input logic [ACC_W-1:0] p);
`ifdef SATURATE_EN
      longint t;
      if (!f) begin
         t = longint'($signed(s)) + longint'($signed(p));
         if (t > 64'sd2147483647)       begin s = 32'h7FFF_FFFF; f = 1'b1; end
         else if (t < -64'sd2147483648) begin s = 32'h8000_0000; f = 1'b1; end
         else s = t[ACC_W-1:0];
      end
`else
      s = s + p;
      f = 1'b0;
`endif
   endtask

   task automatic model_clear();
      m_sa = '0; m_sb = '0; m_fa = 1'b0; m_fb = 1'b0; m_cnt = 0;
   endtask

   // One clock: drive at negedge, sample #1 after the rising edge.
   task automatic step(input logic e, input logic [DATA_W-1:0] a, b, c, d);
      logic [ACC_W-1:0] pr, pi;
      exp_t x;
      @(negedge clk);
      en = e; xn_re = a; xn_im = b; xn4_re = c; xn4_im = d;
      @(posedge clk);
      #1;
      if (e) begin
         ref_prod(a, b, c, d, pr, pi);
         chk("re", re, pr);
         chk("im", im, pi);
         ref_acc(m_sa, m_fa, pr);
         ref_acc(m_sb, m_fb, pi);
         m_cnt++;
         if (m_cnt == WIN_LEN) begin
            x.y_re = m_sa; x.y_im = m_sb; x.due = cyc + 1;
            sbq.push_back(x);
            m_sa = '0; m_sb = '0; m_fa = 1'b0; m_fb = 1'b0; m_cnt = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
   endtask

   task automatic burst(input int n, input logic [DATA_W-1:0] a, b, c, d);
      for (int i = 0; i < n; i++) step(1'b1, a, b, c, d);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_yn_re"}, yn_re, '0);
      chk({tag, "_yn_im"}, yn_im, '0);
      chk({tag, "_counter"}, ACC_W'(counter), '0);
      chk({tag, "_summer_a"}, summer_a, '0);
      chk({tag, "_summer_b"}, summer_b, '0);
      chk({tag, "_re"}, re, '0);
      chk({tag, "_im"}, im, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst");
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      model_clear();
      idle(3);
      check_zero("post_rst");
   endtask

   // Scoreboard: a window sum is due one edge after its 64th accept.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            if (sbq[0].due == cyc) begin
               x = sbq.pop_front();
               chk("yn_re", yn_re, x.y_re);
               chk("yn_im", yn_im, x.y_im);
            end else if (sbq[0].due < cyc) begin
               x = sbq.pop_front();
               checks++; errors++;
               $display("FAIL yn_missed: window due at cycle %0d not checked", x.due);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0;
      xn_re = '0; xn_im = '0; xn4_re = '0; xn4_im = '0;
      model_clear();

      vt[0] = '{16'd1,      16'd0,      16'd1,      16'd0,      32'd1,          32'd0};
      vt[1] = '{16'd0,      16'd1,      16'd1,      16'd0,      32'd0,          32'd1};
      vt[2] = '{16'd3,      16'hFFFE,   16'd1,      16'd4,      32'hFFFF_FFFB,  32'hFFFF_FFF2};
      vt[3] = '{16'd16384,  16'd0,      16'd16384,  16'd0,      32'h1000_0000,  32'd0};
      vt[4] = '{16'h8000,   16'h8000,   16'h8000,   16'h8000,   32'h8000_0000,  32'd0};
      vt[5] = '{16'd100,    16'hFF38,   16'hFED4,   16'd400,    32'hFFFE_5250,  32'd20000};

      // 1: reset, then idle with en low
      do_reset();

      // Product stage against hand-computed vectors; en=0 must hold re/im
      for (int i = 0; i < 6; i++) begin
         step(1'b1, vt[i].a_re, vt[i].a_im, vt[i].b_re, vt[i].b_im);
         chk("tbl_re", re, vt[i].e_re);
         chk("tbl_im", im, vt[i].e_im);
         idle(1);
         chk("tbl_hold_re", re, vt[i].e_re);
         chk("tbl_hold_im", im, vt[i].e_im);
      end
      do_reset();

      // 2: unit samples -> yn=(64,0)
      burst(64, 16'd1, 16'd0, 16'd1, 16'd0);
      idle(2);
      chk("c2_counter", ACC_W'(counter), '0);
      chk("c2_summer_a", summer_a, '0);

      // 3: (0,1)x conj(1,0) -> yn=(0,64)
      burst(64, 16'd0, 16'd1, 16'd1, 16'd0);
      idle(2);

      // 4: window paused by a 10-cycle gap
      burst(32, 16'd1, 16'd0, 16'd1, 16'd0);
      idle(10);
      chk("c4_gap_counter", ACC_W'(counter), 32'd32);
      chk("c4_gap_summer_a", summer_a, m_sa);
      burst(32, 16'd1, 16'd0, 16'd1, 16'd0);
      idle(2);
      chk("c4_counter", ACC_W'(counter), '0);

      // en toggling every cycle
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 16'd3, 16'hFFFE, 16'd1, 16'd4);
         idle(1);
      end
      idle(2);

      // 5: large products, wrap or saturate after the 8th
      burst(8, 16'd16384, 16'd0, 16'd16384, 16'd0);
      idle(1);
      chk("c5_summer_a_8", summer_a, m_sa);
      burst(56, 16'd16384, 16'd0, 16'd16384, 16'd0);
      idle(2);
      chk("c5_counter", ACC_W'(counter), '0);

      // 6: reset aborts a partial window, then a fresh window
      burst(20, 16'd1, 16'd0, 16'd1, 16'd0);
      do_reset();
      burst(64, 16'd1, 16'd0, 16'd1, 16'd0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sbq.size() > 0; i++) idle(1);
      if (sbq.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d window results never checked", sbq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
